// File: rtl/openfire_mem_arbiter.sv
// openfire_mem_arbiter: shares one synchronous-read memory between instruction fetch and
// the load/store port; a data access takes two stalled cycles, then fetch resumes.
module openfire_mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_in,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_sel,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic              stall_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic {FETCH, DWAIT} state_t;

    state_t state, state_nx;
    logic   err_q, we_q;
    logic   req, in_range;
    logic   unused;

    // a request that shows up together with reset is dropped, so no write slips through
    assign req       = dm_req && !reset;
    assign in_range  = ~|dm_addr[31:ADDR_W+2];
    assign if_data   = mem_rdata;
    assign mem_wdata = dm_wdata;
    assign unused    = ^{if_addr[31:ADDR_W], dm_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            err_q <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && req) begin
                err_q <= !in_range;
                we_q  <= dm_we;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        mem_addr  = if_addr[ADDR_W-1:0];
        mem_we    = 4'b0;
        stall_out = stall_in;
        dm_ack    = 1'b0;
        dm_err    = 1'b0;
        dm_rdata  = 32'b0;
        if (state == FETCH) begin
            if (req) begin
                mem_addr  = dm_addr[ADDR_W+1:2];
                mem_we    = (dm_we && in_range) ? dm_sel : 4'b0;
                stall_out = 1'b1;
                state_nx  = DWAIT;
            end
        end else begin
            // the PC is frozen by the stall, so presenting if_addr here re-fetches the same word
            dm_ack    = 1'b1;
            dm_err    = err_q;
            dm_rdata  = (!we_q && !err_q) ? mem_rdata : 32'b0;
            stall_out = 1'b1;
            state_nx  = FETCH;
        end
    end
endmodule

// File: tb/tb_openfire_mem_arbiter.sv
// tb_openfire_mem_arbiter: random fetch/load/store traffic against a word-array memory model.
module tb_openfire_mem_arbiter;
    localparam int AW = 16;

    logic          clock = 0;
    logic          reset = 1;
    logic          stall_in = 0;
    logic [31:0]   if_addr = 0;
    logic [31:0]   if_data;
    logic          dm_req = 0;
    logic          dm_we = 0;
    logic [3:0]    dm_sel = 0;
    logic [31:0]   dm_addr = 0;
    logic [31:0]   dm_wdata = 0;
    logic [31:0]   dm_rdata;
    logic          dm_ack, dm_err, stall_out;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] last_fetch = 0;
    bit          fetch_valid = 0;

    openfire_mem_arbiter #(.ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .stall_in(stall_in),
        .if_addr(if_addr), .if_data(if_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .stall_out(stall_out), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // environment memory: synchronous read returning the pre-write contents
    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // one fetch-only cycle; entered just after a rising edge
    task automatic idle_cycle(input logic [31:0] ia, input logic si);
        dm_req = 0; if_addr = ia; stall_in = si;
        @(negedge clock);
        if (fetch_valid) check("if_data", if_data, ref_mem[last_fetch[AW-1:0]]);
        check("idle_stall", {31'b0, stall_out}, {31'b0, si});
        check("idle_ack", {31'b0, dm_ack}, 32'd0);
        check("idle_we", {28'b0, mem_we}, 32'd0);
        check("idle_addr", {16'b0, mem_addr}, {16'b0, ia[AW-1:0]});
        last_fetch = ia; fetch_valid = 1;
        @(posedge clock); #1;
    endtask

    // one data access, cycles N and N+1; dm_req stays high afterwards when hold is set
    task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        bit          err = (a >= 32'h0004_0000);
        logic [31:0] w   = (a >> 2) & 32'hFFFF;
        logic [31:0] old;
        dm_req = 1; dm_we = we; dm_sel = sel; dm_addr = a; dm_wdata = wd;
        stall_in = 1'($urandom);
        @(negedge clock);
        old = ref_mem[w[AW-1:0]];
        check("n_stall", {31'b0, stall_out}, 32'd1);
        check("n_addr", {16'b0, mem_addr}, w);
        check("n_we", {28'b0, mem_we}, {28'b0, (we && !err) ? sel : 4'b0});
        check("n_ack", {31'b0, dm_ack}, 32'd0);
        if (we && !err) begin
            check("n_wdata", mem_wdata, wd);
            ref_mem[w[AW-1:0]] = merge(old, wd, sel);
        end
        @(posedge clock); #1;
        stall_in = 1'($urandom);
        @(negedge clock);
        check("n1_ack", {31'b0, dm_ack}, 32'd1);
        check("n1_err", {31'b0, dm_err}, {31'b0, err});
        check("n1_rdata", dm_rdata, (!we && !err) ? old : 32'd0);
        check("n1_stall", {31'b0, stall_out}, 32'd1);
        check("n1_addr", {16'b0, mem_addr}, {16'b0, if_addr[AW-1:0]});
        check("n1_we", {28'b0, mem_we}, 32'd0);
        last_fetch = if_addr; fetch_valid = 1;
        @(posedge clock); #1;
        if (!hold) dm_req = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = (i < 256) ? $urandom : 32'd0;
            ref_mem[i] = mem[i];
        end
        mem[16'h10] = 32'hB000_0004; ref_mem[16'h10] = 32'hB000_0004;
        mem[16'h20] = 32'hDEAD_BEEF; ref_mem[16'h20] = 32'hDEAD_BEEF;
        mem[16'h21] = 32'h1122_3344; ref_mem[16'h21] = 32'h1122_3344;

        // a request raised together with reset must not write or stall
        dm_req = 1; dm_we = 1; dm_sel = 4'hF; dm_addr = 32'h40; dm_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check("rst_req_we", {28'b0, mem_we}, 32'd0);
        check("rst_req_stall", {31'b0, stall_out}, 32'd0);
        @(posedge clock); #1;
        reset = 0; dm_req = 0;
        @(negedge clock);
        check("rst_ack", {31'b0, dm_ack}, 32'd0);
        check("rst_err", {31'b0, dm_err}, 32'd0);
        check("rst_rdata", dm_rdata, 32'd0);
        check("rst_stall", {31'b0, stall_out}, 32'd0);
        check("rst_mem10", mem[16'h10], ref_mem[16'h10]);
        @(posedge clock); #1;

        idle_cycle(32'h10, 0);
        idle_cycle(32'h10, 0);
        check("fetch_b0", if_data, 32'hB000_0004);
        access(0, 4'h0, 32'h80, 32'h0, 0);
        idle_cycle(32'h11, 0);
        access(1, 4'b0100, 32'h84, 32'h00AA_0000, 0);
        idle_cycle(32'h12, 0);
        check("byte_store", mem[16'h21], 32'h11AA_3344);
        access(1, 4'hF, 32'h0004_0000, 32'h5555_5555, 0);
        idle_cycle(32'h13, 0);
        check("oor_mem0", mem[0], ref_mem[0]);

        // back-to-back: dm_req held across two accesses
        access(0, 4'h0, 32'h88, 32'h0, 1);
        access(1, 4'b0011, 32'h8C, 32'hCAFE_F00D, 0);
        idle_cycle(32'h14, 0);

        // reset during DWAIT: the store lands, the ack does not follow the reset edge
        dm_req = 1; dm_we = 1; dm_sel = 4'hF; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        ref_mem[16'h40] = 32'h1234_5678;
        reset = 1; dm_req = 0;
        @(posedge clock); #1;
        reset = 0; stall_in = 1;
        @(negedge clock);
        check("rstd_ack", {31'b0, dm_ack}, 32'd0);
        check("rstd_stall", {31'b0, stall_out}, 32'd1);
        check("rstd_mem", mem[16'h40], 32'h1234_5678);
        fetch_valid = 0;
        @(posedge clock); #1;
        idle_cycle(32'h15, 0);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 255), 1'($urandom));
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0004_0000) : ($urandom_range(0, 1023));
            access(1'($urandom), 4'($urandom), a, $urandom, $urandom_range(0, 3) == 0);
        end
        idle_cycle(32'h0, 0);
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
